// File: rtl/cic_interp_sequencer_if.sv
// ============================================================================
// Module      : cic_interp_sequencer_if
// Description : Upstream handshake and CIC strobe/data bundle for the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cic_interp_sequencer_if #(
    parameter int IN_W = 16
);
    logic            run;
    logic            in_valid;
    logic [IN_W-1:0] in_data;
    logic            in_ready;
    logic            cic_en;
    logic            load_result_fast;
    logic            pulse_fast;
    logic            load_result_slow;
    logic            pulse_slow;
    logic            data_select;
    logic [27:0]     cic_sample;
    logic            out_valid;
    logic            underrun;

    modport master (
        output run, in_valid, in_data,
        input  in_ready, cic_en, load_result_fast, pulse_fast, load_result_slow,
               pulse_slow, data_select, cic_sample, out_valid, underrun
    );

    modport slave (
        input  run, in_valid, in_data,
        output in_ready, cic_en, load_result_fast, pulse_fast, load_result_slow,
               pulse_slow, data_select, cic_sample, out_valid, underrun
    );
endinterface

`default_nettype wire

// File: rtl/cic_interp_sequencer.sv
// ============================================================================
// Module      : cic_interp_sequencer
// Description : Strobe generator and one-entry input stage for a 3-stage CIC interpolator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cic_interp_sequencer #(
    parameter int FAST_DIV = 4,
    parameter int INTERP_R = 8,
    parameter int IN_W     = 16
) (
    input  logic clk,
    input  logic rst,
    cic_interp_sequencer_if.slave seq
);

    localparam int CIC_W = 28;
    localparam int CW    = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
    localparam int FW    = (INTERP_R > 1) ? $clog2(INTERP_R) : 1;

    localparam logic [CW-1:0] C_LAST = CW'(FAST_DIV - 1);
    localparam logic [FW-1:0] F_LAST = FW'(INTERP_R - 1);
    localparam logic [CW-1:0] C_ZERO = '0;
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [FW-1:0] F_ZERO = '0;

    logic [CW-1:0]    ccnt_q, ccnt_d;
    logic [FW-1:0]    fcnt_q, fcnt_d;
    logic             buf_valid_q, buf_valid_d;
    logic [IN_W-1:0]  buf_data_q, buf_data_d;
    logic [CIC_W-1:0] sample_q, sample_d;
    logic             underrun_q, underrun_d;

    logic cic_en_q, cic_en_d;
    logic lrf_q, lrf_d;
    logic pf_q, pf_d;
    logic lrs_q, lrs_d;
    logic ps_q, ps_d;
    logic ds_q, ds_d;
    logic ov_q, ov_d;

    logic             run_w;
    logic             transfer_w;
    logic             ccnt_wrap_w;
    logic             last_fast_w;
    logic [CIC_W-1:0] sext_w;

    generate
        if (IN_W < CIC_W) begin : g_sext_pad
            assign sext_w = {{(CIC_W-IN_W){buf_data_q[IN_W-1]}}, buf_data_q};
        end else begin : g_sext_full
            assign sext_w = buf_data_q[CIC_W-1:0];
        end
    endgenerate

    assign run_w       = seq.run;
    assign ccnt_wrap_w = (ccnt_q == C_LAST);
    assign last_fast_w = (fcnt_q == F_LAST);
    assign transfer_w  = run_w && (ccnt_q == C_ZERO) && (fcnt_q == F_ZERO);

    // Phase counters: ccnt paces the fast rate, fcnt counts fast samples per slow sample.
    always_comb begin
        ccnt_d = ccnt_q;
        fcnt_d = fcnt_q;
        if (run_w) begin
            if (ccnt_wrap_w) begin
                ccnt_d = '0;
                fcnt_d = last_fast_w ? '0 : fcnt_q + FW'(1);
            end else begin
                ccnt_d = ccnt_q + CW'(1);
            end
        end
    end

    // Strobes are decoded from the current phase and show up one cycle later.
    always_comb begin
        cic_en_d = run_w;
        lrf_d    = run_w && (ccnt_q == C_ZERO);
        pf_d     = run_w && (ccnt_q == C_ONE);
        lrs_d    = run_w && last_fast_w && (ccnt_q == C_ZERO);
        ps_d     = run_w && last_fast_w && (ccnt_q == C_ONE);
        ds_d     = run_w && (fcnt_q == F_ZERO);
        ov_d     = lrf_q;
    end

    // A write colliding with an empty-buffer transfer still counts as an underrun;
    // the incoming sample is kept for the following slow period.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        sample_d    = sample_q;
        underrun_d  = underrun_q;
        if (transfer_w) begin
            if (buf_valid_q) begin
                sample_d    = sext_w;
                buf_valid_d = 1'b0;
            end else begin
                sample_d    = '0;
                underrun_d  = 1'b1;
            end
        end
        if (seq.in_valid && !buf_valid_q) begin
            buf_data_d  = seq.in_data;
            buf_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ccnt_q      <= '0;
            fcnt_q      <= '0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
            sample_q    <= '0;
            underrun_q  <= 1'b0;
            cic_en_q    <= 1'b0;
            lrf_q       <= 1'b0;
            pf_q        <= 1'b0;
            lrs_q       <= 1'b0;
            ps_q        <= 1'b0;
            ds_q        <= 1'b0;
            ov_q        <= 1'b0;
        end else begin
            ccnt_q      <= ccnt_d;
            fcnt_q      <= fcnt_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            sample_q    <= sample_d;
            underrun_q  <= underrun_d;
            cic_en_q    <= cic_en_d;
            lrf_q       <= lrf_d;
            pf_q        <= pf_d;
            lrs_q       <= lrs_d;
            ps_q        <= ps_d;
            ds_q        <= ds_d;
            ov_q        <= ov_d;
        end
    end

    assign seq.in_ready         = !buf_valid_q;
    assign seq.cic_en           = cic_en_q;
    assign seq.load_result_fast = lrf_q;
    assign seq.pulse_fast       = pf_q;
    assign seq.load_result_slow = lrs_q;
    assign seq.pulse_slow       = ps_q;
    assign seq.data_select      = ds_q;
    assign seq.cic_sample       = sample_q;
    assign seq.out_valid        = ov_q;
    assign seq.underrun         = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_cic_interp_sequencer.sv
// ============================================================================
// Module      : tb_cic_interp_sequencer
// Description : Scoreboard bench for cic_interp_sequencer against a phase-count reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cic_interp_sequencer;

    localparam int FD   = 4;
    localparam int R    = 8;
    localparam int PER  = FD * R;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cic_interp_sequencer_if #(.IN_W(16)) bus ();

    cic_interp_sequencer #(.FAST_DIV(FD), .INTERP_R(R), .IN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .seq (bus)
    );

    always #5 clk = ~clk;

    // obs = {in_ready, cic_en, lrf, pf, lrs, ps, ds, out_valid, underrun, cic_sample[27:0]}
    typedef struct packed {
        logic [36:0] obs;
        logic        win;
        logic [1:0]  tag;
    } rec_t;

    rec_t exp_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_lrf = 0, n_pf = 0, n_lrs = 0, n_ps = 0, n_ds = 0;
    int ps_after_lrs = 0;

    // Reference model state: phase as a single run-cycle count within the slow period.
    int          m_t;
    logic [15:0] m_buf[$];
    logic [27:0] m_sample;
    bit          m_under;
    bit          m_prev_lrf;

    logic [15:0] src[$];

    task automatic step(input bit r, input bit rn, input bit v, input logic [15:0] d,
                        input bit w, input logic [1:0] tg, output bit acc);
        rec_t        e;
        bit          full;
        int          c, f;
        logic [15:0] h;
        acc = 1'b0;
        e   = '0;
        if (r) begin
            m_t = 0;
            m_buf.delete();
            m_sample   = '0;
            m_under    = 1'b0;
            m_prev_lrf = 1'b0;
            e.obs[36]  = 1'b1;
        end else begin
            c = m_t % FD;
            f = m_t / FD;
            e.obs[35] = rn;
            e.obs[34] = rn && (c == 0);
            e.obs[33] = rn && (c == 1);
            e.obs[32] = rn && (f == R - 1) && (c == 0);
            e.obs[31] = rn && (f == R - 1) && (c == 1);
            e.obs[30] = rn && (f == 0);
            e.obs[29] = m_prev_lrf;
            full = (m_buf.size() != 0);
            if (rn && m_t == 0) begin
                if (full) begin
                    h = m_buf.pop_front();
                    m_sample = {{12{h[15]}}, h};
                end else begin
                    m_sample = '0;
                    m_under  = 1'b1;
                end
            end
            if (v && !full) begin
                m_buf.push_back(d);
                acc = 1'b1;
            end
            e.obs[36]    = (m_buf.size() == 0);
            e.obs[28]    = m_under;
            e.obs[27:0]  = m_sample;
            m_prev_lrf   = e.obs[34];
            if (rn) m_t = (m_t + 1) % PER;
        end
        e.win = w;
        e.tag = tg;
        exp_q.push_back(e);
    endtask

    // One driven cycle: apply inputs, predict, consume source on acceptance.
    task automatic drive(input bit r, input bit rn, input bit v, input bit w, input logic [1:0] tg);
        bit          acc;
        logic [15:0] d;
        @(negedge clk);
        d = (src.size() != 0) ? src[0] : 16'($urandom);
        rst          = r;
        bus.run      = rn;
        bus.in_valid = v && (src.size() != 0);
        bus.in_data  = d;
        step(r, rn, bus.in_valid, d, w, tg, acc);
        if (acc) void'(src.pop_front());
    endtask

    // Monitor: pops one expectation per clock and compares against the DUT.
    initial begin
        rec_t        e;
        logic [36:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                cyc++;
                got = {bus.in_ready, bus.cic_en, bus.load_result_fast, bus.pulse_fast,
                       bus.load_result_slow, bus.pulse_slow, bus.data_select, bus.out_valid,
                       bus.underrun, bus.cic_sample};
                total++;
                if (got !== e.obs) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got=%h exp=%h", cyc, got, e.obs);
                end
                if (e.tag == 2'd1) begin
                    total++;
                    if (bus.cic_sample !== 28'hFFF8000) begin
                        bad++;
                        $display("FAIL neg_full_scale got=%h exp=%h", bus.cic_sample, 28'hFFF8000);
                    end
                end else if (e.tag == 2'd2) begin
                    total++;
                    if (bus.cic_sample !== 28'h0007FFF) begin
                        bad++;
                        $display("FAIL pos_full_scale got=%h exp=%h", bus.cic_sample, 28'h0007FFF);
                    end
                end else if (e.tag == 2'd3) begin
                    total++;
                    if (bus.underrun !== 1'b1) begin
                        bad++;
                        $display("FAIL underrun_sticky got=%b exp=1", bus.underrun);
                    end
                end
                if (e.win) begin
                    n_lrf += int'(bus.load_result_fast);
                    n_pf  += int'(bus.pulse_fast);
                    n_ps  += int'(bus.pulse_slow);
                    n_ds  += int'(bus.data_select);
                    if (bus.pulse_slow && ps_after_lrs == 1) ps_after_lrs = 2;
                    if (bus.load_result_slow) begin
                        n_lrs++;
                        ps_after_lrs = 1;
                    end else if (ps_after_lrs == 1) begin
                        ps_after_lrs = 3;
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int expv);
        total++;
        if (got != expv) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, expv);
        end
    endtask

    initial begin
        logic [1:0] tg;
        bus.run      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset held for several cycles.
        repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // Continuous run; first transfer finds the buffer empty while 8000 is written.
        src.push_back(16'h8000);
        src.push_back(16'h7FFF);
        for (int k = 0; k < 96; k++) begin
            tg = 2'd0;
            if (k == 33 || k == 63) tg = 2'd1;
            if (k == 65 || k == 95) tg = 2'd2;
            if (k == 80)            tg = 2'd3;
            drive(1'b0, 1'b1, 1'b1, (k < 64), tg);
        end

        // Freeze at fcnt=3, ccnt=2 for 10 cycles, then resume.
        for (int k = 0; k < 200 && m_t != 14; k++) drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        repeat (10) drive(1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        repeat (12) drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);

        // Reset mid-period at fcnt=5.
        for (int k = 0; k < 200 && m_t != 20; k++) drive(1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'd0);
        repeat (40) drive(1'b0, 1'b1, 1'b1, 1'b0, 2'd0);

        // Randomized traffic with occasional freezes and resets.
        for (int k = 0; k < 1500; k++) begin
            if (src.size() == 0) src.push_back(16'($urandom));
            drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 2) != 0), 1'b0, 2'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        check("lrf_count_64", n_lrf, 16);
        check("pf_count_64", n_pf, 16);
        check("lrs_count_64", n_lrs, 2);
        check("ps_count_64", n_ps, 2);
        check("ds_count_64", n_ds, 8);
        check("ps_follows_lrs", ps_after_lrs, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
